fpu_result_collector: RTL and testbench
=======================================

# fpu_result_collector

Consumer-side endpoint for the FPU functional units: accepts the single-cycle `valid`/result/flags pulses that each unit emits, such as the compare, min/max, add, mul and div units. Each pulse is buffered in a per-unit holding register. A round-robin arbiter forwards one result per cycle over a valid/ready writeback port, routed to the integer or FP register file. While forwarding, the block formats the data (zero-extension or NaN-boxing) and accumulates exception flags into the architectural `fflags` register. It sits between the FPU execute units and the writeback stage.

## Interface
Parameters:
- `NUM_UNITS`, 4: number of FPU result producers; legal range 2–8.
- `FLEN`, 64: FP register width.
- `XLEN`, 32: integer register width.
- `TAG_W`, 5: destination register tag width.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset; synchronous, active-high.
- `i_unit_valid` in `[NUM_UNITS]`: one-cycle result pulse per unit; units have no backpressure.
- `i_unit_result` in `[NUM_UNITS][FLEN]`: raw unit result.
- `i_unit_to_int` in `[NUM_UNITS]`: 1 means the destination is the integer regfile (FEQ/FLT/FLE/FCLASS/FMV.X).
- `i_unit_single` in `[NUM_UNITS]`: single-precision FP result.
- `i_unit_flags` in `[NUM_UNITS]` of `riscv_pkg::fp_flags_t`: nv/dz/of/uf/nx.
- `i_unit_tag` in `[NUM_UNITS][TAG_W]`: destination register.
- `o_wb_valid` out 1: writeback request.
- `i_wb_ready` in 1: writeback accepts.
- `o_wb_data` out FLEN: formatted result.
- `o_wb_to_int` out 1: route to the integer regfile.
- `o_wb_tag` out `TAG_W`: destination register.
- `i_fflags_we` in 1: CSR write to `fflags`.
- `i_fflags_wdata` in 5: CSR write data.
- `o_fflags` out 5: architectural accrued flags.
- `o_busy` out 1: any holding register or the output register is occupied.
- `o_overflow` out 1: sticky; a unit pulse was dropped.

## Operation
- **Holding registers.** Each unit has one entry (`valid`, result, `to_int`, `single`, flags, tag).
  - The entry loads on `i_unit_valid[k]`.
  - It clears when granted, unless a new pulse from the same unit arrives in that cycle; in that case the new pulse loads.
- **Overflow.** A pulse arriving while the entry is full and not granted in that cycle is dropped. The block sets `o_overflow` and leaves the entry unchanged. `o_overflow` clears only on reset.
- **Arbitration.** Round-robin over valid holding entries, starting at pointer `ptr`.
  - A grant occurs when the output register is empty or is being accepted in the same cycle (`o_wb_valid && i_wb_ready`).
  - On a grant to unit k, `ptr` becomes `(k+1) mod NUM_UNITS`.
- **Formatting**, applied when loading the output register:
  - `to_int`: `{(FLEN-XLEN)'0, result[XLEN-1:0]}`.
  - FP with `single`: `{(FLEN-32)'1, result[31:0]}` (NaN-boxed).
  - FP double: the result unchanged.
- **Output register.** Holds data, `to_int`, tag and flags.
  - It stays stable while `o_wb_valid && !i_wb_ready`.
  - It clears on accept when no new grant occurs.
- **fflags update.**
  - On accept, `fflags <= fflags | out_flags`.
  - If `i_fflags_we` is asserted in the same cycle, `fflags <= i_fflags_wdata | out_flags`, so accepted flags are never lost.
  - With `i_fflags_we` and no accept, `fflags <= i_fflags_wdata`.

## Timing
- **Reset values:** all outputs 0 (`o_wb_valid`, `o_wb_data`, `o_wb_to_int`, `o_wb_tag`, `o_fflags`, `o_busy`, `o_overflow`); `ptr` = 0; all holding valids 0.
- **Latency:** a pulse in cycle N reaches the holding register at edge N+1. With an idle path, the grant and output-register load happen at edge N+2, so `o_wb_valid` is high in cycle N+2.
- **Throughput:** one accepted result per cycle with `i_wb_ready` held high.
- **fflags visibility:** the `o_fflags` update is visible the cycle after accept.
- **Starvation bound:** with ready held high, a waiting entry is granted within `NUM_UNITS` cycles.
- **Reset mid-operation:** all buffered results are discarded; nothing is emitted after reset deasserts.

## Structure
- Add `fpu_wb_t` (data, `to_int`, tag, flags) to `riscv_pkg`; reuse `riscv_pkg::fp_flags_t`.
- Sub-module `fpu_rr_arbiter`, parameterized by `NUM_UNITS`: request vector and pointer in, one-hot grant and next pointer out; combinational.

## Test plan
- **Single compare result:** unit 0 pulses result 1, `to_int`=1, tag 7, flags 0 → `o_wb_valid` two cycles later with data `64'h1`, `o_wb_to_int`=1, `o_wb_tag`=7; `o_fflags` stays 0.
- **NaN-boxing:** unit 1 pulses single FP `32'h3F80_0000`, `to_int`=0 → `o_wb_data` = `64'hFFFF_FFFF_3F80_0000`.
- **Simultaneous pulses:** all 4 units pulse together, ready high → four consecutive writebacks in order 0,1,2,3; with the pointer pre-set to 2 by a prior grant to unit 1, order is 2,3,0,1.
- **Backpressure and overflow:** ready low for 10 cycles with two pulses from unit 2 → the first result holds steady on the output; the second pulse from unit 2 arrives while its entry is full and not granted, so it is dropped and `o_overflow`=1; with ready then high, exactly one result from unit 2 emerges.
- **Flag accrual vs CSR write:** accept with flags nv=1 in the same cycle as `i_fflags_we` with wdata `5'b00001` → `o_fflags` = `5'b10001`.
- **Reset mid-operation:** reset while 3 entries are pending → all outputs 0 next cycle; no writeback after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V types used by the FPU writeback path.
package riscv_pkg;

    localparam int RV_FLEN  = 64;
    localparam int RV_XLEN  = 32;
    localparam int RV_TAG_W = 5;

    // IEEE-754 exception flags in fflags bit order (nv is bit 4, nx is bit 0)
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    // One formatted FPU writeback beat
    typedef struct packed {
        logic [RV_FLEN-1:0]  data;
        logic                to_int;
        logic [RV_TAG_W-1:0] tag;
        fp_flags_t           flags;
    } fpu_wb_t;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps; the
// pointer advances to just past the winner.
module fpu_rr_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int PTR_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic [NUM_UNITS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_UNITS-1:0] gnt,
    output logic [PTR_W-1:0]     ptr_nxt,
    output logic                 any_gnt
);

    logic [PTR_W-1:0] idx;

    // Walk requesters in priority order from ptr, first hit wins
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        any_gnt = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_UNITS);
            if (!any_gnt && req[idx]) begin
                any_gnt  = 1'b1;
                gnt[idx] = 1'b1;
                ptr_nxt  = PTR_W'((int'(idx) + 1) % NUM_UNITS);
            end
        end
    end

endmodule

// File: rtl/fpu_result_collector.sv
// Collects single-cycle FPU unit results into per-unit holding entries and
// forwards them one per cycle over a valid/ready writeback port, formatting
// data (zero-extend / NaN-box) and accruing exception flags into fflags.
module fpu_result_collector
    import riscv_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int FLEN      = 64,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_UNITS-1:0]            i_unit_valid,
    input  logic [NUM_UNITS-1:0][FLEN-1:0]  i_unit_result,
    input  logic [NUM_UNITS-1:0]            i_unit_to_int,
    input  logic [NUM_UNITS-1:0]            i_unit_single,
    input  fp_flags_t [NUM_UNITS-1:0]       i_unit_flags,
    input  logic [NUM_UNITS-1:0][TAG_W-1:0] i_unit_tag,
    output logic                            o_wb_valid,
    input  logic                            i_wb_ready,
    output logic [FLEN-1:0]                 o_wb_data,
    output logic                            o_wb_to_int,
    output logic [TAG_W-1:0]                o_wb_tag,
    input  logic                            i_fflags_we,
    input  logic [4:0]                      i_fflags_wdata,
    output logic [4:0]                      o_fflags,
    output logic                            o_busy,
    output logic                            o_overflow
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    // Holding entries, one per unit
    logic [NUM_UNITS-1:0]            hold_vld;
    logic [NUM_UNITS-1:0][FLEN-1:0]  hold_result;
    logic [NUM_UNITS-1:0]            hold_to_int;
    logic [NUM_UNITS-1:0]            hold_single;
    fp_flags_t [NUM_UNITS-1:0]       hold_flags;
    logic [NUM_UNITS-1:0][TAG_W-1:0] hold_tag;
    logic [NUM_UNITS-1:0]            hold_load;
    logic [NUM_UNITS-1:0]            drop;

    // Arbitration
    logic [NUM_UNITS-1:0] req;
    logic [NUM_UNITS-1:0] gnt;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_nxt;
    logic                 any_gnt;
    logic                 accept;
    logic                 can_grant;

    // Output register and the granted entry before formatting
    fpu_wb_t          out_q;
    fpu_wb_t          out_d;
    logic             out_vld;
    logic [FLEN-1:0]  sel_result;
    logic             sel_to_int;
    logic             sel_single;
    fp_flags_t        sel_flags;
    logic [TAG_W-1:0] sel_tag;

    logic [4:0] fflags_q;
    logic       overflow_q;

    assign accept    = out_vld && i_wb_ready;
    // Only arbitrate when the output slot will be free at the next edge
    assign can_grant = !out_vld || accept;
    assign req       = can_grant ? hold_vld : '0;

    fpu_rr_arbiter #(
        .NUM_UNITS (NUM_UNITS),
        .PTR_W     (PTR_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt),
        .any_gnt (any_gnt)
    );

    // A pulse loads if the entry is empty or is being drained this cycle;
    // otherwise it has nowhere to go and is lost
    assign hold_load = i_unit_valid & (~hold_vld | gnt);
    assign drop      = i_unit_valid & hold_vld & ~gnt;

    // Holding entry valid bits: load wins over grant-clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_vld <= '0;
        end else begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (hold_load[k])
                    hold_vld[k] <= 1'b1;
                else if (gnt[k])
                    hold_vld[k] <= 1'b0;
            end
        end
    end

    // Holding entry payload; contents are don't-care while invalid
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (hold_load[k]) begin
                hold_result[k] <= i_unit_result[k];
                hold_to_int[k] <= i_unit_to_int[k];
                hold_single[k] <= i_unit_single[k];
                hold_flags[k]  <= i_unit_flags[k];
                hold_tag[k]    <= i_unit_tag[k];
            end
        end
    end

    // One-hot mux of the granted entry
    always_comb begin
        sel_result = '0;
        sel_to_int = 1'b0;
        sel_single = 1'b0;
        sel_flags  = '0;
        sel_tag    = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (gnt[k]) begin
                sel_result = sel_result | hold_result[k];
                sel_to_int = sel_to_int | hold_to_int[k];
                sel_single = sel_single | hold_single[k];
                sel_flags  = sel_flags  | hold_flags[k];
                sel_tag    = sel_tag    | hold_tag[k];
            end
        end
    end

    // Format the granted result for its destination register file
    always_comb begin
        out_d        = '0;
        out_d.to_int = sel_to_int;
        out_d.tag    = sel_tag;
        out_d.flags  = sel_flags;
        if (sel_to_int)
            out_d.data = {{(FLEN-XLEN){1'b0}}, sel_result[XLEN-1:0]};
        else if (sel_single)
            out_d.data = {{(FLEN-32){1'b1}}, sel_result[31:0]};
        else
            out_d.data = sel_result;
    end

    // Output register: load on grant, hold under backpressure, clear on drain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (any_gnt) begin
            out_vld <= 1'b1;
            out_q   <= out_d;
        end else if (accept) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end
    end

    // Round-robin pointer moves only on an actual grant
    always_ff @(posedge i_clk) begin
        if (i_rst)
            ptr <= '0;
        else if (any_gnt)
            ptr <= ptr_nxt;
    end

    // fflags: a CSR write replaces the accrued value but never masks the
    // flags of a result accepted in the same cycle
    always_ff @(posedge i_clk) begin
        if (i_rst)
            fflags_q <= '0;
        else if (i_fflags_we)
            fflags_q <= i_fflags_wdata | (accept ? 5'(out_q.flags) : 5'b0);
        else if (accept)
            fflags_q <= fflags_q | 5'(out_q.flags);
    end

    // Sticky overflow on any dropped pulse
    always_ff @(posedge i_clk) begin
        if (i_rst)
            overflow_q <= 1'b0;
        else if (|drop)
            overflow_q <= 1'b1;
    end

    assign o_wb_valid  = out_vld;
    assign o_wb_data   = out_q.data;
    assign o_wb_to_int = out_q.to_int;
    assign o_wb_tag    = out_q.tag;
    assign o_fflags    = fflags_q;
    assign o_busy      = out_vld || (|hold_vld);
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Self-checking bench for fpu_result_collector: directed table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_fpu_result_collector;
    import riscv_pkg::*;

    localparam int NU = 4;
    localparam int FL = 64;
    localparam int XL = 32;
    localparam int TW = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NU-1:0]          uv;
    logic [NU-1:0][FL-1:0]  ures;
    logic [NU-1:0]          u_int;
    logic [NU-1:0]          u_sgl;
    fp_flags_t [NU-1:0]     ufl;
    logic [NU-1:0][TW-1:0]  utag;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [FL-1:0]          wb_data;
    logic                   wb_to_int;
    logic [TW-1:0]          wb_tag;
    logic                   ff_we;
    logic [4:0]             ff_wdata;
    logic [4:0]             fflags;
    logic                   busy;
    logic                   ovf;

    int n_vec = 0;
    int n_err = 0;

    fpu_result_collector #(
        .NUM_UNITS (NU),
        .FLEN      (FL),
        .XLEN      (XL),
        .TAG_W     (TW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_unit_valid   (uv),
        .i_unit_result  (ures),
        .i_unit_to_int  (u_int),
        .i_unit_single  (u_sgl),
        .i_unit_flags   (ufl),
        .i_unit_tag     (utag),
        .o_wb_valid     (wb_valid),
        .i_wb_ready     (wb_ready),
        .o_wb_data      (wb_data),
        .o_wb_to_int    (wb_to_int),
        .o_wb_tag       (wb_tag),
        .i_fflags_we    (ff_we),
        .i_fflags_wdata (ff_wdata),
        .o_fflags       (fflags),
        .o_busy         (busy),
        .o_overflow     (ovf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_pv   [NU];
    logic [63:0] m_pres [NU];
    bit          m_pint [NU];
    bit          m_psgl [NU];
    logic [4:0]  m_pfl  [NU];
    logic [TW-1:0] m_ptag [NU];
    bit          m_ov;
    logic [63:0] m_od;
    bit          m_oint;
    logic [TW-1:0] m_otag;
    logic [4:0]  m_ofl;
    int          m_ptr;
    logic [4:0]  m_ff;
    bit          m_ovf;

    function automatic logic [63:0] fmt(logic [63:0] r, bit ti, bit sg);
        if (ti) return r & 64'h0000_0000_FFFF_FFFF;
        if (sg) return (r & 64'h0000_0000_FFFF_FFFF) | 64'hFFFF_FFFF_0000_0000;
        return r;
    endfunction

    task automatic model_step();
        bit acc;
        int g;
        if (rst) begin
            for (int k = 0; k < NU; k++) m_pv[k] = 0;
            m_ov = 0; m_od = '0; m_oint = 0; m_otag = '0; m_ofl = '0;
            m_ptr = 0; m_ff = '0; m_ovf = 0;
            return;
        end
        acc = m_ov && wb_ready;
        g = -1;
        if (!m_ov || acc)
            for (int i = 0; i < NU; i++)
                if (g < 0 && m_pv[(m_ptr + i) % NU]) g = (m_ptr + i) % NU;
        if (ff_we) m_ff = ff_wdata | (acc ? m_ofl : 5'b0);
        else if (acc) m_ff = m_ff | m_ofl;
        if (g >= 0) begin
            m_ov   = 1;
            m_od   = fmt(m_pres[g], m_pint[g], m_psgl[g]);
            m_oint = m_pint[g];
            m_otag = m_ptag[g];
            m_ofl  = m_pfl[g];
            m_ptr  = (g + 1) % NU;
        end else if (acc) begin
            m_ov = 0;
        end
        for (int k = 0; k < NU; k++) begin
            if (uv[k]) begin
                if (m_pv[k] && k != g) m_ovf = 1;
                else begin
                    m_pv[k] = 1; m_pres[k] = ures[k]; m_pint[k] = u_int[k];
                    m_psgl[k] = u_sgl[k]; m_pfl[k] = ufl[k]; m_ptag[k] = utag[k];
                end
            end else if (k == g) begin
                m_pv[k] = 0;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        bit mb;
        @(posedge clk);
        model_step();
        #1;
        mb = m_ov;
        for (int k = 0; k < NU; k++) mb = mb | m_pv[k];
        chk("model wb_valid", wb_valid, m_ov);
        chk("model fflags", fflags, m_ff);
        chk("model busy", busy, mb);
        chk("model overflow", ovf, m_ovf);
        if (m_ov) begin
            chk("model wb_data", wb_data, m_od);
            chk("model wb_to_int", wb_to_int, m_oint);
            chk("model wb_tag", wb_tag, m_otag);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " wb_valid"}, wb_valid, 0);
        chk({nm, " wb_data"}, wb_data, 0);
        chk({nm, " wb_to_int"}, wb_to_int, 0);
        chk({nm, " wb_tag"}, wb_tag, 0);
        chk({nm, " fflags"}, fflags, 0);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " overflow"}, ovf, 0);
    endtask

    task automatic idle();
        uv    = '0;
        ff_we = 1'b0;
    endtask

    task automatic pulse(input int k, input logic [63:0] r, input bit ti, input bit sg,
                         input logic [TW-1:0] tg, input logic [4:0] fl);
        uv[k]    = 1'b1;
        ures[k]  = r;
        u_int[k] = ti;
        u_sgl[k] = sg;
        utag[k]  = tg;
        ufl[k]   = fp_flags_t'(fl);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          unit;
        logic [63:0] result;
        bit          to_int;
        bit          single;
        logic [TW-1:0] tag;
        logic [4:0]  flags;
        logic [63:0] exp_data;
        logic [4:0]  exp_ff;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [TW-1:0] order_a [4];
        int n22, n23, n20;

        rst = 1'b1; uv = '0; ures = '0; u_int = '0; u_sgl = '0; ufl = '0; utag = '0;
        wb_ready = 1'b0; ff_we = 1'b0; ff_wdata = '0;

        tbl[0] = '{0, 64'h1,                   1, 0, 5'd7,  5'b00000, 64'h0000_0000_0000_0001, 5'b00000};
        tbl[1] = '{1, 64'h3F80_0000,           0, 1, 5'd3,  5'b00000, 64'hFFFF_FFFF_3F80_0000, 5'b00000};
        tbl[2] = '{2, 64'h4000_0000_0000_0000, 0, 0, 5'd9,  5'b00000, 64'h4000_0000_0000_0000, 5'b00000};
        tbl[3] = '{3, 64'hDEAD_BEEF_1234_5678, 1, 0, 5'd31, 5'b00000, 64'h0000_0000_1234_5678, 5'b00000};
        tbl[4] = '{0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 1, 5'd1,  5'b00001, 64'hFFFF_FFFF_CCCC_DDDD, 5'b00001};

        // reset state
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;

        // single results through an idle path: visible two cycles after the pulse
        wb_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pulse(tbl[i].unit, tbl[i].result, tbl[i].to_int, tbl[i].single, tbl[i].tag, tbl[i].flags);
            tick();
            idle();
            tick();
            chk("tbl wb_valid", wb_valid, 1);
            chk("tbl wb_data", wb_data, tbl[i].exp_data);
            chk("tbl wb_to_int", wb_to_int, tbl[i].to_int);
            chk("tbl wb_tag", wb_tag, tbl[i].tag);
            tick();
            chk("tbl fflags", fflags, tbl[i].exp_ff);
        end

        // simultaneous pulses from pointer 0
        do_reset();
        wb_ready = 1'b1;
        for (int k = 0; k < NU; k++) pulse(k, 64'(k + 100), 1, 0, TW'(10 + k), 5'b0);
        tick();
        idle();
        for (int j = 0; j < NU; j++) begin
            tick();
            chk("order0 tag", wb_tag, 64'(10 + j));
            chk("order0 valid", wb_valid, 1);
        end
        tick();
        // grant to unit 1 leaves the pointer at 2
        pulse(1, 64'h55, 1, 0, 5'd11, 5'b0);
        tick();
        idle();
        tick();
        tick();
        order_a[0] = 5'd12; order_a[1] = 5'd13; order_a[2] = 5'd10; order_a[3] = 5'd11;
        for (int k = 0; k < NU; k++) pulse(k, 64'(k + 200), 1, 0, TW'(10 + k), 5'b0);
        tick();
        idle();
        for (int j = 0; j < NU; j++) begin
            tick();
            chk("order2 tag", wb_tag, order_a[j]);
        end
        tick();

        // backpressure and overflow
        do_reset();
        wb_ready = 1'b0;
        pulse(0, 64'h20, 1, 0, 5'd20, 5'b0);
        tick();
        idle();
        tick();
        pulse(2, 64'h22, 1, 0, 5'd22, 5'b0);
        tick();
        idle();
        tick();
        chk("bp no overflow yet", ovf, 0);
        pulse(2, 64'h23, 1, 0, 5'd23, 5'b0);
        tick();
        idle();
        chk("bp overflow", ovf, 1);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("bp steady tag", wb_tag, 20);
            chk("bp steady data", wb_data, 64'h20);
        end
        wb_ready = 1'b1;
        n20 = 1; n22 = 0; n23 = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (wb_valid && wb_tag == 5'd22) n22++;
            if (wb_valid && wb_tag == 5'd23) n23++;
            if (wb_valid && wb_tag == 5'd20) n20++;
        end
        chk("bp unit2 count", n22, 1);
        chk("bp dropped count", n23, 0);
        chk("bp unit0 count", n20, 1);
        chk("bp overflow sticky", ovf, 1);

        // flag accrual racing a CSR write
        do_reset();
        wb_ready = 1'b0;
        pulse(0, 64'h7, 0, 0, 5'd1, 5'b10000);
        tick();
        idle();
        tick();
        wb_ready = 1'b1;
        ff_we    = 1'b1;
        ff_wdata = 5'b00001;
        tick();
        idle();
        chk("fflags merge", fflags, 5'b10001);
        tick();

        // reset with three entries pending
        wb_ready = 1'b0;
        for (int k = 0; k < 3; k++) pulse(k, 64'(k + 300), 0, 0, TW'(k + 4), 5'b11111);
        tick();
        idle();
        chk("pre-reset busy", busy, 1);
        rst = 1'b1;
        tick();
        chk_zero("midreset");
        rst = 1'b0;
        wb_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("post-reset no wb", wb_valid, 0);
        end

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NU; k++) begin
                uv[k]    = ($urandom_range(0, 99) < 30);
                ures[k]  = {$urandom, $urandom};
                u_int[k] = $urandom_range(0, 1);
                u_sgl[k] = $urandom_range(0, 1);
                utag[k]  = TW'($urandom_range(0, 31));
                ufl[k]   = fp_flags_t'(5'($urandom_range(0, 31)));
            end
            wb_ready = ($urandom_range(0, 99) < 70);
            ff_we    = ($urandom_range(0, 99) < 5);
            ff_wdata = 5'($urandom_range(0, 31));
            rst      = ($urandom_range(0, 199) == 0);
            tick();
        end
        idle();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
